sc_conv_controller: RTL
=======================

# sc_conv_controller

Parametrised successor to the stochastic-computing convolution sequencer. It walks an IN_WIDTH × IN_HEIGHT output grid and, for every pixel, accumulates NUM_CH input channels. Each channel runs a STREAM_LEN-cycle bitstream, timed by an internal counter instead of an external done strobe. Results are released over a valid/ready handshake, so a stalled consumer freezes the array cleanly.

## Interface
Parameters:
- IN_WIDTH, 4, output columns (≥1)
- IN_HEIGHT, 3, output rows (≥1)
- STREAM_LEN, 8, bitstream cycles per channel (≥1)
- NUM_CH, 2, channels accumulated per pixel (≥1)

Ports (W(x) = max(1, $clog2(x))):
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all counters
- start  in  1  begin a frame; sampled only in IDLE
- input_ready  in  1  operand buffer holds the next channel's data
- output_ready  in  1  consumer accepts the current result
- abort  in  1  cancel the frame; used only with CTRL_ABORT_EN
- input_req  out  1  request the next channel's operands
- pe_reset, pe_init, pe_enable, sng_enable  out  1 each  PE/SNG controls
- partial_sum_reset, partial_sum_enable  out  1 each  accumulator controls
- output_valid  out  1  result available
- done  out  1  one-cycle end-of-frame pulse
- busy  out  1  high in every state except IDLE
- width_index  out  W(IN_WIDTH)  current column
- height_index  out  W(IN_HEIGHT)  current row
- ch_index  out  W(NUM_CH)  current channel

## Operation
- Outputs are Moore-decoded from the state only. Any signal not listed for a state is 0.
- IDLE: all outputs 0. start=1 → CLEAR.
- CLEAR (1 cycle): pe_reset, partial_sum_reset. width/height/ch indices ← 0. → WAIT_INPUT.
- WAIT_INPUT: input_req. input_ready=1 → INIT; otherwise hold.
- INIT (1 cycle): pe_init. sc_count ← 0. → STREAM.
- STREAM: pe_enable, sng_enable. sc_count increments every cycle. At sc_count==STREAM_LEN-1 → ACCUM. STREAM therefore lasts exactly STREAM_LEN cycles.
- ACCUM (1 cycle): partial_sum_enable.
  - ch_index==NUM_CH-1: ch_index ← 0, → OUTPUT.
  - Otherwise: ch_index+1, → WAIT_INPUT.
- OUTPUT: output_valid held, with all enables low, until output_ready=1 → ADVANCE. output_valid must not drop before the handshake completes.
- ADVANCE (1 cycle): partial_sum_reset.
  - Last pixel (width_index==IN_WIDTH-1 and height_index==IN_HEIGHT-1): → DONE, indices unchanged.
  - End of row (width_index==IN_WIDTH-1): width_index ← 0, height_index+1, → WAIT_INPUT.
  - Otherwise: width_index+1, → WAIT_INPUT.
- DONE (1 cycle): done. → IDLE. Indices keep their final values until the next CLEAR.
- start is ignored while busy. A start held high in DONE's following IDLE cycle launches a new frame.
- Index counters never exceed their maximum. No wrap occurs beyond the frame.

## Timing
- With input_ready and output_ready tied high, each pixel takes NUM_CH·(STREAM_LEN+3)+2 cycles.
- A frame takes 1 + pixels·per_pixel + 1 cycles. Cycle 1 is CLEAR, the first cycle after the edge that samples start.
- input_ready and output_ready are sampled on the rising edge. The transition happens on the same edge; there is no extra latency.
- Asynchronous reset mid-frame: every output is 0 and every index is 0 immediately, without waiting for a clock edge. Operation resumes in IDLE after deassertion.
- Simultaneous events:
  - input_ready high outside WAIT_INPUT: ignored.
  - output_ready high outside OUTPUT: ignored.

## Configuration
- CTRL_ABORT_EN defined:
  - abort=1 in any non-IDLE state → IDLE at the next edge. abort has priority over all other transitions.
  - Counters are cleared.
  - done is not pulsed.
- CTRL_ABORT_EN undefined: the abort port exists but is ignored, and there is no abort logic.

## Test plan
- Defaults, ready inputs tied high, start pulsed: done is high in exactly cycle 290 after the start edge. The bench counts 12 output_valid cycles, with (width, height) running (0,0),(1,0)…(3,2), row-major.
- Per channel: pe_enable high for exactly 8 consecutive cycles. partial_sum_enable pulses twice per pixel, with ch_index 0 then 1.
- input_ready held low for 5 cycles in WAIT_INPUT: input_req stays high for those cycles and STREAM is delayed by exactly 5 cycles. output_ready held low for 7 cycles: output_valid stays high for 8 cycles, with pe_enable low throughout.
- Asynchronous reset asserted mid-STREAM on pixel (2,1): all outputs and indices are 0 before the next clock edge. A new start restarts the frame at (0,0).
- With CTRL_ABORT_EN defined, abort asserted in OUTPUT: IDLE on the next edge, busy=0, done is never pulsed. Without the macro, the same stimulus leaves the sequence unchanged.
- STREAM_LEN=1, NUM_CH=1, IN_WIDTH=IN_HEIGHT=1: the frame completes with done in cycle 8.

Source files
------------

// File: rtl/sc_conv_controller.sv
`default_nettype none
// ============================================================================
// Module   : sc_conv_controller
// Brief    : Stochastic-computing convolution sequencer; walks the output grid,
//            streams NUM_CH channels per pixel, hands results off via valid/ready.
//            Optional abort path is compiled in with `define CTRL_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sc_conv_controller #(
   parameter int IN_WIDTH   = 4,
   parameter int IN_HEIGHT  = 3,
   parameter int STREAM_LEN = 8,
   parameter int NUM_CH     = 2,
   localparam int c_WW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1,
   localparam int c_HW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1,
   localparam int c_CW = (NUM_CH    > 1) ? $clog2(NUM_CH)    : 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            input_ready,
   input  logic            output_ready,
   input  logic            abort,
   output logic            input_req,
   output logic            pe_reset,
   output logic            pe_init,
   output logic            pe_enable,
   output logic            sng_enable,
   output logic            partial_sum_reset,
   output logic            partial_sum_enable,
   output logic            output_valid,
   output logic            done,
   output logic            busy,
   output logic [c_WW-1:0] width_index,
   output logic [c_HW-1:0] height_index,
   output logic [c_CW-1:0] ch_index
);

   localparam int c_SW = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_CLEAR      = 4'd1;
   localparam logic [3:0] S_WAIT_INPUT = 4'd2;
   localparam logic [3:0] S_INIT       = 4'd3;
   localparam logic [3:0] S_STREAM     = 4'd4;
   localparam logic [3:0] S_ACCUM      = 4'd5;
   localparam logic [3:0] S_OUTPUT     = 4'd6;
   localparam logic [3:0] S_ADVANCE    = 4'd7;
   localparam logic [3:0] S_DONE       = 4'd8;

   localparam logic [c_WW-1:0] c_W_LAST = c_WW'(IN_WIDTH - 1);
   localparam logic [c_HW-1:0] c_H_LAST = c_HW'(IN_HEIGHT - 1);
   localparam logic [c_CW-1:0] c_C_LAST = c_CW'(NUM_CH - 1);
   localparam logic [c_SW-1:0] c_S_LAST = c_SW'(STREAM_LEN - 1);
   localparam logic [c_WW-1:0] c_W_ONE  = c_WW'(1);
   localparam logic [c_HW-1:0] c_H_ONE  = c_HW'(1);
   localparam logic [c_CW-1:0] c_C_ONE  = c_CW'(1);
   localparam logic [c_SW-1:0] c_S_ONE  = c_SW'(1);

   logic [3:0]      r_state;
   logic [3:0]      w_next_state;
   logic [c_WW-1:0] r_width_index;
   logic [c_HW-1:0] r_height_index;
   logic [c_CW-1:0] r_ch_index;
   logic [c_SW-1:0] r_sc_count;

   logic w_last_col;
   logic w_last_row;
   logic w_last_ch;
   logic w_last_bit;

   assign w_last_col = (r_width_index  == c_W_LAST);
   assign w_last_row = (r_height_index == c_H_LAST);
   assign w_last_ch  = (r_ch_index     == c_C_LAST);
   assign w_last_bit = (r_sc_count     == c_S_LAST);

`ifdef CTRL_ABORT_EN
   logic w_abort;
   assign w_abort = abort && (r_state != S_IDLE);
`else
   logic w_unused_abort;
   assign w_unused_abort = abort;
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:       if (start)        w_next_state = S_CLEAR;
         S_CLEAR:                        w_next_state = S_WAIT_INPUT;
         S_WAIT_INPUT: if (input_ready)  w_next_state = S_INIT;
         S_INIT:                         w_next_state = S_STREAM;
         S_STREAM:     if (w_last_bit)   w_next_state = S_ACCUM;
         S_ACCUM:      w_next_state = w_last_ch ? S_OUTPUT : S_WAIT_INPUT;
         S_OUTPUT:     if (output_ready) w_next_state = S_ADVANCE;
         S_ADVANCE:    w_next_state = (w_last_col && w_last_row) ? S_DONE : S_WAIT_INPUT;
         S_DONE:                         w_next_state = S_IDLE;
         default:                        w_next_state = S_IDLE;
      endcase
`ifdef CTRL_ABORT_EN
      if (w_abort) w_next_state = S_IDLE;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_width_index  <= '0;
         r_height_index <= '0;
         r_ch_index     <= '0;
         r_sc_count     <= '0;
      end
`ifdef CTRL_ABORT_EN
      else if (w_abort) begin
         r_state        <= S_IDLE;
         r_width_index  <= '0;
         r_height_index <= '0;
         r_ch_index     <= '0;
         r_sc_count     <= '0;
      end
`endif
      else begin
         r_state <= w_next_state;
         case (r_state)
            S_CLEAR: begin
               r_width_index  <= '0;
               r_height_index <= '0;
               r_ch_index     <= '0;
               r_sc_count     <= '0;
            end
            S_INIT: r_sc_count <= '0;
            // Hold at the last count so a power-of-two length never wraps.
            S_STREAM: if (!w_last_bit) r_sc_count <= r_sc_count + c_S_ONE;
            S_ACCUM: r_ch_index <= w_last_ch ? '0 : r_ch_index + c_C_ONE;
            S_ADVANCE: begin
               if (w_last_col) begin
                  if (!w_last_row) begin
                     r_width_index  <= '0;
                     r_height_index <= r_height_index + c_H_ONE;
                  end
               end else begin
                  r_width_index <= r_width_index + c_W_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      input_req          = 1'b0;
      pe_reset           = 1'b0;
      pe_init            = 1'b0;
      pe_enable          = 1'b0;
      sng_enable         = 1'b0;
      partial_sum_reset  = 1'b0;
      partial_sum_enable = 1'b0;
      output_valid       = 1'b0;
      done               = 1'b0;
      case (r_state)
         S_CLEAR: begin
            pe_reset          = 1'b1;
            partial_sum_reset = 1'b1;
         end
         S_WAIT_INPUT: input_req = 1'b1;
         S_INIT:       pe_init   = 1'b1;
         S_STREAM: begin
            pe_enable  = 1'b1;
            sng_enable = 1'b1;
         end
         S_ACCUM:   partial_sum_enable = 1'b1;
         S_OUTPUT:  output_valid       = 1'b1;
         S_ADVANCE: partial_sum_reset  = 1'b1;
         S_DONE:    done               = 1'b1;
         default: ;
      endcase
   end

   assign busy         = (r_state != S_IDLE);
   assign width_index  = r_width_index;
   assign height_index = r_height_index;
   assign ch_index     = r_ch_index;

endmodule
`default_nettype wire
